// File: rtl/unidade_controle_genius.sv
// Moore control unit for the memory-sequence game: sequences the rodada/endereco
// counters, jogada register and per-move timeout from datapath status flags.
module unidade_controle_genius #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       jogada_correta,
  input  logic       endereco_igual_rodada,
  input  logic       rodada_final,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       contaR,
  output logic       registraR,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    NOVA_RODADA = 4'h2,
    ESPERA      = 4'h3,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROX_JOGADA = 4'h6,
    PROX_RODADA = 4'h7,
    FIM_GANHOU  = 4'hC,
    FIM_PERDEU  = 4'hD,
    FIM_TIMEOUT = 4'hE
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox;
  logic [TW-1:0] r_tmo;
  logic          w_timeout;

  assign w_timeout = (r_tmo == TMO_MAX);

  // Counter only runs while staying in ESPERA; any entry into ESPERA starts it from 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_tmo    <= '0;
    end else begin
      r_estado <= w_prox;
      if (w_prox == ESPERA && r_estado == ESPERA && !w_timeout)
        r_tmo <= r_tmo + 1'b1;
      else if (w_prox == ESPERA && r_estado == ESPERA)
        r_tmo <= r_tmo;
      else
        r_tmo <= '0;
    end
  end

  always_comb begin
    w_prox = INICIAL;
    case (r_estado)
      INICIAL:     w_prox = jogar ? PREPARA : INICIAL;
      PREPARA:     w_prox = NOVA_RODADA;
      NOVA_RODADA: w_prox = ESPERA;
      ESPERA: begin
        if (tem_jogada)     w_prox = REGISTRA;
        else if (w_timeout) w_prox = FIM_TIMEOUT;
        else                w_prox = ESPERA;
      end
      REGISTRA:    w_prox = COMPARA;
      COMPARA: begin
        if (!jogada_correta)                            w_prox = FIM_PERDEU;
        else if (endereco_igual_rodada && rodada_final) w_prox = FIM_GANHOU;
        else if (endereco_igual_rodada)                 w_prox = PROX_RODADA;
        else                                            w_prox = PROX_JOGADA;
      end
      PROX_JOGADA: w_prox = ESPERA;
      PROX_RODADA: w_prox = NOVA_RODADA;
      FIM_GANHOU:  w_prox = jogar ? PREPARA : FIM_GANHOU;
      FIM_PERDEU:  w_prox = jogar ? PREPARA : FIM_PERDEU;
      FIM_TIMEOUT: w_prox = jogar ? PREPARA : FIM_TIMEOUT;
      default:     w_prox = INICIAL;
    endcase
  end

  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraR      = 1'b0;
    contaR     = 1'b0;
    registraR  = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    pronto     = 1'b0;
    db_timeout = 1'b0;
    case (r_estado)
      PREPARA:     begin zeraE = 1'b1; zeraR = 1'b1; end
      NOVA_RODADA: zeraE = 1'b1;
      REGISTRA:    registraR = 1'b1;
      PROX_JOGADA: contaE = 1'b1;
      PROX_RODADA: contaR = 1'b1;
      FIM_GANHOU:  begin ganhou = 1'b1; pronto = 1'b1; end
      FIM_PERDEU:  begin perdeu = 1'b1; pronto = 1'b1; end
      FIM_TIMEOUT: begin perdeu = 1'b1; pronto = 1'b1; db_timeout = 1'b1; end
      default:     ;
    endcase
  end

  assign db_estado = r_estado;

endmodule
